// File: rtl/alarme.sv
// alarme: alarm stage placed after the hour/minute/second counters.
// Holds an editable alarm time and rings a 1 Hz beep when the running time
// reaches hh:mm:00. Supports snooze, stop and an automatic ring timeout.
// Ports:
//   main_clock, main_reset     clock, asynchronous active-high reset
//   enable_1hz                 one-cycle pulse per second
//   h/m/s_msd, h/m/s_lsd       current time in BCD
//   alarm_en                   level enable; low cancels any alarm
//   btn_set_h/_m/_stop/_snooze asynchronous debounced buttons, active-high
//   al_h/m_msd, al_h/m_lsd     alarm time in BCD (registered)
//   buzzer, alarm_active, snoozing  registered status outputs
module alarme #(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60
) (
  input  logic       main_clock,
  input  logic       main_reset,
  input  logic       enable_1hz,
  input  logic [2:0] h_msd,
  input  logic [3:0] h_lsd,
  input  logic [2:0] m_msd,
  input  logic [3:0] m_lsd,
  input  logic [2:0] s_msd,
  input  logic [3:0] s_lsd,
  input  logic       alarm_en,
  input  logic       btn_set_h,
  input  logic       btn_set_m,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [2:0] al_h_msd,
  output logic [3:0] al_h_lsd,
  output logic [2:0] al_m_msd,
  output logic [3:0] al_m_lsd,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       snoozing
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LIMIT  = 8'(RING_TIMEOUT_S);

  state_t      r_state;
  logic [2:0]  r_al_h_msd;
  logic [3:0]  r_al_h_lsd;
  logic [2:0]  r_al_m_msd;
  logic [3:0]  r_al_m_lsd;
  logic [7:0]  r_ring_cnt;
  logic [11:0] r_snz_cnt;
  logic        r_beep;
  logic        r_buzzer;
  logic        r_active;
  logic        r_snoozing;
  logic        r_match_q;

  // Button bit order: {snooze, stop, set_m, set_h}
  logic [3:0]  r_btn_s1;
  logic [3:0]  r_btn_s2;
  logic [3:0]  r_btn_prev;
  logic [3:0]  w_btn_evt;

  logic        w_ev_set_h;
  logic        w_ev_set_m;
  logic        w_ev_stop;
  logic        w_ev_snooze;
  logic        w_match;
  logic        w_trigger;

  logic [2:0]  w_h_msd_nx;
  logic [3:0]  w_h_lsd_nx;
  logic [2:0]  w_m_msd_nx;
  logic [3:0]  w_m_lsd_nx;

  // Two-flop synchronizers plus a previous-value flop for edge detection
  always_ff @(posedge main_clock or posedge main_reset) begin
    if (main_reset) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_s1   <= {btn_snooze, btn_stop, btn_set_m, btn_set_h};
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
    end
  end

  assign w_btn_evt   = r_btn_s2 & ~r_btn_prev;
  assign w_ev_set_h  = w_btn_evt[0];
  assign w_ev_set_m  = w_btn_evt[1];
  assign w_ev_stop   = w_btn_evt[2];
  assign w_ev_snooze = w_btn_evt[3];

  assign w_match = (h_msd == r_al_h_msd) && (h_lsd == r_al_h_lsd) &&
                   (m_msd == r_al_m_msd) && (m_lsd == r_al_m_lsd) &&
                   (s_msd == 3'd0) && (s_lsd == 4'd0);
  // Rising edge of match only, so a held hh:mm:00 fires once
  assign w_trigger = w_match & ~r_match_q;

  // BCD hour increment, 23 wraps to 00
  always_comb begin
    w_h_msd_nx = r_al_h_msd;
    w_h_lsd_nx = r_al_h_lsd;
    if (r_al_h_msd == 3'd2 && r_al_h_lsd == 4'd3) begin
      w_h_msd_nx = 3'd0;
      w_h_lsd_nx = 4'd0;
    end else if (r_al_h_lsd == 4'd9) begin
      w_h_msd_nx = r_al_h_msd + 3'd1;
      w_h_lsd_nx = 4'd0;
    end else begin
      w_h_lsd_nx = r_al_h_lsd + 4'd1;
    end
  end

  // BCD minute increment, 59 wraps to 00 without carrying into the hour
  always_comb begin
    w_m_msd_nx = r_al_m_msd;
    w_m_lsd_nx = r_al_m_lsd;
    if (r_al_m_lsd == 4'd9) begin
      w_m_lsd_nx = 4'd0;
      w_m_msd_nx = (r_al_m_msd == 3'd5) ? 3'd0 : r_al_m_msd + 3'd1;
    end else begin
      w_m_lsd_nx = r_al_m_lsd + 4'd1;
    end
  end

  always_ff @(posedge main_clock or posedge main_reset) begin
    if (main_reset) begin
      r_state    <= IDLE;
      r_al_h_msd <= 3'd0;
      r_al_h_lsd <= 4'd6;
      r_al_m_msd <= 3'd0;
      r_al_m_lsd <= 4'd0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_beep     <= 1'b0;
      r_buzzer   <= 1'b0;
      r_active   <= 1'b0;
      r_snoozing <= 1'b0;
      r_match_q  <= 1'b0;
    end else begin
      r_match_q <= w_match;
      case (r_state)
        IDLE: begin
          if (w_ev_set_h) begin
            r_al_h_msd <= w_h_msd_nx;
            r_al_h_lsd <= w_h_lsd_nx;
          end
          if (w_ev_set_m) begin
            r_al_m_msd <= w_m_msd_nx;
            r_al_m_lsd <= w_m_lsd_nx;
          end
          if (w_trigger && alarm_en) begin
            r_state    <= RINGING;
            r_ring_cnt <= '0;
            r_beep     <= 1'b1;
            r_buzzer   <= 1'b1;
            r_active   <= 1'b1;
          end
        end
        RINGING: begin
          if (!alarm_en || w_ev_stop) begin
            r_state    <= IDLE;
            r_buzzer   <= 1'b0;
            r_active   <= 1'b0;
            r_snoozing <= 1'b0;
          end else if (w_ev_snooze) begin
            r_state    <= SNOOZE;
            r_snz_cnt  <= SNOOZE_LOAD;
            r_buzzer   <= 1'b0;
            r_snoozing <= 1'b1;
          end else if (enable_1hz) begin
            // Exit on the pulse that would make the count reach the limit
            if (r_ring_cnt + 8'd1 == RING_LIMIT) begin
              r_state    <= IDLE;
              r_buzzer   <= 1'b0;
              r_active   <= 1'b0;
              r_snoozing <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + 8'd1;
              r_beep     <= ~r_beep;
              r_buzzer   <= ~r_beep;
            end
          end
        end
        SNOOZE: begin
          if (!alarm_en || w_ev_stop) begin
            r_state    <= IDLE;
            r_buzzer   <= 1'b0;
            r_active   <= 1'b0;
            r_snoozing <= 1'b0;
          end else if (enable_1hz) begin
            if (r_snz_cnt == 12'd1) begin
              r_state    <= RINGING;
              r_ring_cnt <= '0;
              r_beep     <= 1'b1;
              r_buzzer   <= 1'b1;
              r_snoozing <= 1'b0;
            end else begin
              r_snz_cnt <= r_snz_cnt - 12'd1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_buzzer   <= 1'b0;
          r_active   <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign al_h_msd     = r_al_h_msd;
  assign al_h_lsd     = r_al_h_lsd;
  assign al_m_msd     = r_al_m_msd;
  assign al_m_lsd     = r_al_m_lsd;
  assign buzzer       = r_buzzer;
  assign alarm_active = r_active;
  assign snoozing     = r_snoozing;

endmodule

// File: tb/tb_alarme.sv
// tb_alarme: self-checking bench for alarme (SNOOZE_MIN=1, RING_TIMEOUT_S=60).
// Expected output vectors are queued when stimulus is applied and compared
// against sampled DUT outputs at the end of each scenario task.
module tb_alarme;

  logic       main_clock = 1'b0;
  logic       main_reset = 1'b0;
  logic       enable_1hz = 1'b0;
  logic [2:0] h_msd = 3'd1, m_msd = 3'd3, s_msd = 3'd5;
  logic [3:0] h_lsd = 4'd2, m_lsd = 4'd4, s_lsd = 4'd6;
  logic       alarm_en = 1'b0;
  logic [3:0] btn = 4'b0000; // {snooze, stop, set_m, set_h}
  logic [2:0] al_h_msd, al_m_msd;
  logic [3:0] al_h_lsd, al_m_lsd;
  logic       buzzer, alarm_active, snoozing;
  logic [16:0] w_obs;

  localparam logic [3:0] B_SETH = 4'b0001;
  localparam logic [3:0] B_SETM = 4'b0010;
  localparam logic [3:0] B_STOP = 4'b0100;
  localparam logic [3:0] B_SNZ  = 4'b1000;

  always #5 main_clock = ~main_clock;

  alarme #(.SNOOZE_MIN(1), .RING_TIMEOUT_S(60)) dut (
    .main_clock(main_clock), .main_reset(main_reset), .enable_1hz(enable_1hz),
    .h_msd(h_msd), .h_lsd(h_lsd), .m_msd(m_msd), .m_lsd(m_lsd),
    .s_msd(s_msd), .s_lsd(s_lsd), .alarm_en(alarm_en),
    .btn_set_h(btn[0]), .btn_set_m(btn[1]), .btn_stop(btn[2]), .btn_snooze(btn[3]),
    .al_h_msd(al_h_msd), .al_h_lsd(al_h_lsd), .al_m_msd(al_m_msd), .al_m_lsd(al_m_lsd),
    .buzzer(buzzer), .alarm_active(alarm_active), .snoozing(snoozing)
  );

  assign w_obs = {al_h_msd, al_h_lsd, al_m_msd, al_m_lsd, buzzer, alarm_active, snoozing};

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  string       tag_q[$];
  int          al_hh = 6;
  int          al_mm = 0;

  function automatic logic [16:0] ev(int hh, int mm, logic b, logic a, logic s);
    logic [2:0] hm; logic [3:0] hl; logic [2:0] mm1; logic [3:0] ml;
    hm = 3'(hh / 10); hl = 4'(hh % 10); mm1 = 3'(mm / 10); ml = 4'(mm % 10);
    return {hm, hl, mm1, ml, b, a, s};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge main_clock); #1; end
  endtask

  task automatic expect_v(input logic [16:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sample(input string tag);
    obs_q.push_back(w_obs);
    tag_q.push_back(tag);
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    h_msd = 3'(hh / 10); h_lsd = 4'(hh % 10);
    m_msd = 3'(mm / 10); m_lsd = 4'(mm % 10);
    s_msd = 3'(ss / 10); s_lsd = 4'(ss % 10);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; step(3); btn = 4'b0000; step(3);
  endtask

  task automatic pulse();
    enable_1hz = 1'b1; step(1); enable_1hz = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] e, o; string t;
    main_reset = 1'b1;
    expect_v(ev(6, 0, 0, 0, 0));
    #2 sample("reset_async");
    step(2); main_reset = 1'b0; step(2);
    expect_v(ev(6, 0, 0, 0, 0));
    sample("reset_release");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_edit();
    logic [16:0] e, o; string t;
    btn = B_SETH;
    expect_v(ev(al_hh, al_mm, 0, 0, 0));
    step(2); sample("seth_latency_2");
    al_hh = 7;
    expect_v(ev(al_hh, al_mm, 0, 0, 0));
    step(1); sample("seth_latency_3");
    btn = 4'b0000; step(3);
    for (int i = 0; i < 17; i++) begin
      al_hh = (al_hh + 1) % 24;
      expect_v(ev(al_hh, al_mm, 0, 0, 0));
      press(B_SETH); sample("seth_step");
    end
    al_hh = 1;
    expect_v(ev(al_hh, al_mm, 0, 0, 0));
    btn = B_SETH; step(10); btn = 4'b0000; step(3);
    sample("seth_held_once");
    for (int i = 0; i < 60; i++) begin
      al_mm = (al_mm + 1) % 60;
      expect_v(ev(al_hh, al_mm, 0, 0, 0));
      press(B_SETM); sample("setm_step");
    end
    for (int i = 0; i < 5; i++) press(B_SETH);
    al_hh = 6;
    expect_v(ev(al_hh, al_mm, 0, 0, 0));
    sample("seth_back_to_06");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_ring_stop();
    logic [16:0] e, o; string t;
    alarm_en = 1'b1;
    set_time(5, 59, 59);
    expect_v(ev(6, 0, 0, 0, 0));
    step(1); sample("pre_match_idle");
    set_time(6, 0, 0);
    expect_v(ev(6, 0, 1, 1, 0));
    step(1); sample("ring_rise");
    expect_v(ev(6, 0, 0, 1, 0)); pulse(); sample("beep_toggle1");
    expect_v(ev(6, 0, 1, 1, 0)); pulse(); sample("beep_toggle2");
    expect_v(ev(6, 0, 0, 1, 0)); pulse(); sample("beep_toggle3");
    expect_v(ev(6, 0, 0, 1, 0)); press(B_SETH); sample("edit_ignored_ringing");
    expect_v(ev(6, 0, 0, 1, 0)); press(B_SETM); sample("editm_ignored_ringing");
    expect_v(ev(6, 0, 0, 0, 0)); press(B_STOP); sample("stop_to_idle");
    expect_v(ev(6, 0, 0, 0, 0)); step(4); sample("no_retrigger_after_stop");
    set_time(6, 0, 1); step(1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_snooze();
    logic [16:0] e, o; string t;
    set_time(6, 0, 0);
    expect_v(ev(6, 0, 1, 1, 0));
    step(1); sample("snz_ring");
    expect_v(ev(6, 0, 0, 1, 1));
    press(B_SNZ); sample("snz_enter");
    expect_v(ev(6, 0, 0, 1, 1));
    repeat (59) pulse();
    sample("snz_59_pulses");
    expect_v(ev(6, 0, 1, 1, 0));
    pulse(); sample("snz_expire_ring");
    expect_v(ev(6, 0, 0, 1, 0));
    pulse(); sample("snz_ring_toggle");
    expect_v(ev(6, 0, 0, 0, 0));
    press(B_STOP); sample("snz_stop");
    set_time(6, 0, 1); step(1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_timeout();
    logic [16:0] e, o; string t;
    set_time(6, 0, 0);
    expect_v(ev(6, 0, 1, 1, 0));
    step(1); sample("to_ring");
    expect_v(ev(6, 0, 0, 1, 0));
    repeat (59) pulse();
    sample("to_59_pulses");
    expect_v(ev(6, 0, 0, 0, 0));
    pulse(); sample("to_60th_idle");
    expect_v(ev(6, 0, 0, 0, 0));
    step(5); pulse(); sample("to_no_retrigger");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_coincident();
    logic [16:0] e, o; string t;
    set_time(6, 0, 1); step(1);
    set_time(6, 0, 0);
    expect_v(ev(6, 0, 1, 1, 0)); step(1); sample("co_ring");
    expect_v(ev(6, 0, 0, 0, 0)); press(B_STOP | B_SNZ); sample("co_stop_beats_snooze");
    set_time(6, 0, 1); step(1); set_time(6, 0, 0);
    expect_v(ev(6, 0, 1, 1, 0)); step(1); sample("co_ring2");
    expect_v(ev(6, 0, 0, 1, 1)); press(B_SNZ); sample("co_snooze");
    alarm_en = 1'b0;
    expect_v(ev(6, 0, 0, 0, 0)); step(1); sample("co_en_off_snooze");
    set_time(6, 0, 1); step(1); set_time(6, 0, 0);
    expect_v(ev(6, 0, 0, 0, 0)); step(2); sample("co_disabled_no_ring");
    alarm_en = 1'b1;
    expect_v(ev(6, 1, 0, 0, 0)); press(B_SETM); sample("co_set_0601");
    set_time(6, 1, 0);
    expect_v(ev(6, 1, 1, 1, 0)); step(1); sample("co_ring_0601");
    expect_v(ev(6, 1, 0, 1, 1)); press(B_SNZ); sample("co_snooze_0601");
    pulse(); pulse(); pulse();
    main_reset = 1'b1;
    expect_v(ev(6, 0, 0, 0, 0)); #2 sample("co_reset_in_snooze");
    step(2); main_reset = 1'b0;
    expect_v(ev(6, 0, 0, 0, 0)); step(3); sample("co_after_reset");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_edit();
    test_ring_stop();
    test_snooze();
    test_timeout();
    test_coincident();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
